// File: rtl/unified_mem_arbiter.sv
// Arbitrates one instruction-fetch port and one data port onto a shared
// single-port synchronous-read memory, one access per two cycles.
module unified_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant_d;   // 1 = data port was granted most recently
  logic   misalign_q;
  logic   grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      misalign_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_i) last_grant_d <= 1'b0;
      if (grant_d) begin
        last_grant_d <= 1'b1;
        misalign_q   <= (d_addr[1:0] != 2'b00);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && d_req) begin
          // Tie: fixed priority favours data, otherwise the port not served last
          if (FIXED_PRI || !last_grant_d) grant_d = 1'b1;
          else                            grant_i = 1'b1;
        end else begin
          grant_i = if_req;
          grant_d = d_req;
        end
        if (grant_d)      state_nxt = RESP_D;
        else if (grant_i) state_nxt = RESP_I;
      end
      RESP_I:  state_nxt = IDLE;
      RESP_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if_valid   = 1'b0;
    if_rdata   = '0;
    d_done     = 1'b0;
    d_rdata    = '0;
    d_misalign = 1'b0;
    if (!reset) begin
      if (grant_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (grant_i) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      if (state == RESP_I) begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      if (state == RESP_D) begin
        d_done     = 1'b1;
        d_rdata    = mem_rdata;
        d_misalign = misalign_q;
      end
    end
  end

  assign stall = !reset && ((if_req && !if_valid) || (d_req && !d_done));

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32: byte-address width of both requester ports and the memory port.
REQ-002 The block SHALL take parameter FIXED_PRI, default 0: 0 selects round-robin arbitration, 1 selects fixed data-port priority.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port if_req, input, 1 bit: instruction-fetch request; held high until if_valid.
REQ-006 The block SHALL have port if_addr, input, ADDR_W bits: fetch byte address; stable while if_req is high.
REQ-007 The block SHALL have port if_valid, output, 1 bit: one-cycle pulse; if_rdata is valid in that cycle.
REQ-008 The block SHALL have port if_rdata, output, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port d_req, input, 1 bit: data-access request; held high until d_done.
REQ-010 The block SHALL have port d_we, input, 1 bit: 1 = store, 0 = load; stable while d_req is high.
REQ-011 The block SHALL have port d_addr, input, ADDR_W bits: data byte address.
REQ-012 The block SHALL have port d_wdata, input, 32 bits: store data.
REQ-013 The block SHALL have port d_done, output, 1 bit: one-cycle completion pulse for loads and stores.
REQ-014 The block SHALL have port d_rdata, output, 32 bits: load data, valid while d_done is high.
REQ-015 The block SHALL have port d_misalign, output, 1 bit: asserted with d_done when d_addr[1:0] != 0.
REQ-016 The block SHALL have ports mem_en, output, 1 bit; mem_we, output, 1 bit; mem_addr, output, ADDR_W bits; mem_wdata, output, 32 bits: the shared single-port memory command.
REQ-017 The block SHALL have port mem_rdata, input, 32 bits: memory read data, valid one cycle after a read command (synchronous read).
REQ-018 The block SHALL have port stall, output, 1 bit: high whenever any requester has an uncompleted request in this cycle.

Function
REQ-019 FSM states SHALL be IDLE, RESP_I and RESP_D.
REQ-020 In IDLE with exactly one request high, that requester SHALL be granted: mem_en=1, mem_addr/mem_we/mem_wdata taken combinationally from it (mem_we=0 for fetch), next state RESP_I or RESP_D.
REQ-021 In IDLE with both requests high and FIXED_PRI=1, the data port SHALL win.
REQ-022 In IDLE with both requests high and FIXED_PRI=0, the port not granted last SHALL win; the last_grant register SHALL update on every grant.
REQ-023 In IDLE with no request, mem_en SHALL be 0 and the state SHALL remain IDLE.
REQ-024 RESP_I SHALL assert if_valid=1 with if_rdata=mem_rdata; RESP_D SHALL assert d_done=1 with d_rdata=mem_rdata (d_rdata is don't-care for stores); both states return to IDLE.
REQ-025 No memory command SHALL be issued in RESP_I or RESP_D; throughput is one access per 2 cycles and latency is request-cycle + 1.
REQ-026 The losing requester SHALL see stall=1 and no response pulse; it is granted in the IDLE cycle that follows, so worst-case wait is 2 cycles under round-robin.
REQ-027 Deasserting the granted request during RESP SHALL NOT cancel the response pulse.
REQ-028 mem_addr SHALL be the full byte address unmodified; misaligned data accesses SHALL still be issued, with d_misalign=1 accompanying d_done.
REQ-029 if_rdata and d_rdata SHALL be 0 in all cycles without their respective pulse.
REQ-030 stall SHALL be (if_req & ~if_valid) | (d_req & ~d_done).

Reset
REQ-031 While reset=1 at a clock edge, the state SHALL become IDLE, last_grant SHALL become data (first tie goes to fetch), and no pulse SHALL be asserted in the following cycle.
REQ-032 While reset is high, mem_en, mem_we, if_valid, d_done, d_misalign and stall SHALL be 0, and all data outputs SHALL be 0.
REQ-033 A reset that arrives during RESP_I or RESP_D SHALL abort the transaction with no response pulse; the requester re-requests.

Verification
REQ-034 Fetch only: if_req=1, if_addr=0x10, mem returns 0x00500093 -> cycle 0 mem_en=1, mem_addr=0x10; cycle 1 if_valid=1, if_rdata=0x00500093.
REQ-035 Tie, FIXED_PRI=0, after reset: both requests high -> fetch granted first, then data on the next IDLE cycle; the next tie goes to fetch.
REQ-036 Tie, FIXED_PRI=1: both requests high continuously -> data is granted each IDLE cycle it requests; fetch is granted only when d_req=0.
REQ-037 Store: d_req=1, d_we=1, d_addr=0x24, d_wdata=0xDEADBEEF -> mem_we=1 with those values, then d_done=1, d_misalign=0.
REQ-038 Misaligned load: d_addr=0x22 -> access issued and d_done=1 with d_misalign=1; reset asserted during RESP_D instead -> no d_done, state IDLE.
